lcd_port_driver: RTL and testbench
==================================

// Module: lcd_port_driver
// PURPOSE
//  Consumer end of the core's memory-mapped LCD output register.
//  Turns each command word the core writes to io_lcd_o into a timed HD44780 write cycle on the LCD pins: setup, EN pulse, hold, then a settle wait.
//  It reports completion back through a toggle acknowledge that software reads via an input port.
//  Sits at top level between the core's io_lcd_o and the board LCD pins.
// PARAMETERS
//  T_POWERUP     1000000  cycles after reset before the first command is accepted (20 ms @50 MHz)
//  T_SETUP       4        cycles RS/DATA stable before EN rises (>=1)
//  T_PULSE       25       cycles EN held high (>=1)
//  T_HOLD        4        cycles RS/DATA held after EN falls (>=1)
//  T_WAIT_SHORT  2000     settle cycles for normal commands and data (>=1)
//  T_WAIT_LONG   82000    settle cycles for clear/home (>=1)
// PORTS
//  clk_i       in   1   system clock
//  rst_ni      in   1   reset, asynchronous, active-low
//  lcd_word_i  in   32  core LCD register: [31]=ON, [30]=REQ toggle, [8]=RS, [7:0]=DATA, rest ignored
//  lcd_on_o    out  1   LCD power/backlight enable
//  lcd_rs_o    out  1   register select
//  lcd_rw_o    out  1   read/write; constant 0 (write-only)
//  lcd_en_o    out  1   enable strobe
//  lcd_data_o  out  8   data bus
//  busy_o      out  1   1 while initialising or executing a command
//  ack_o       out  1   REQ value of the last completed command (toggle handshake)
// BEHAVIOUR
//  Reset: lcd_on_o=0, rs=0, rw=0, en=0, data=8'h00, busy_o=1, ack_o=0, state=INIT, counter=0.
//   Assertion of rst_ni takes effect immediately, including mid-command: EN drops at once and the command is abandoned.
//  lcd_on_o: registered copy of lcd_word_i[31], 1-cycle latency, updated in every state.
//  Counter: one down-counter, width $clog2(max of all T_*)+1.
//   Load value N on state entry gives exactly N cycles in that state.
//  States:
//   INIT: busy=1 for T_POWERUP cycles, then go to IDLE with busy=0.
//    REQ toggles during INIT are not lost; they are seen in IDLE.
//   IDLE: busy=0, en=0.
//    A request is pending when lcd_word_i[30] != ack_o.
//    On a pending request at edge k: capture RS=[8], DATA=[7:0] and REQ=[30].
//    After that edge: rs/data outputs valid, busy=1, state=SETUP.
//    Later changes to lcd_word_i[30:0] are ignored until the next IDLE.
//   SETUP: en=0 for T_SETUP cycles, then go to PULSE.
//   PULSE: en=1 for T_PULSE cycles, then go to HOLD.
//   HOLD: en=0, rs/data held for T_HOLD cycles, then go to WAIT.
//   WAIT: long wait applies when RS=0 and DATA[7:2]=0 and DATA[1:0]!=0 (clear/home).
//    Long wait = T_WAIT_LONG cycles; otherwise T_WAIT_SHORT cycles.
//    On the final WAIT edge: ack_o <= captured REQ, busy_o <= 0, state=IDLE.
//  rs/data retain the last command's values while idle.
//  Latency from accept edge to ack edge = T_SETUP+T_PULSE+T_HOLD+T_WAIT_x cycles.
//  Back-to-back commands: a new request can be accepted on the first IDLE cycle after ack.
//  Software contract: toggle REQ only when ack_o==REQ.
//   A double toggle while busy is treated as no request. This is the required behaviour, not an error.
// TESTING  (T_POWERUP=10, T_SETUP=2, T_PULSE=3, T_HOLD=2, T_WAIT_SHORT=5, T_WAIT_LONG=20)
//  1. Reset, hold word=32'h0 -> busy_o=1 for 10 cycles then 0; en never high; ack_o stays 0.
//  2. After init, write 32'h4000_0141 (REQ=1, RS=1, data 'A') -> rs=1, data=8'h41 one cycle later.
//     Then en=0 for 2 cycles, en=1 for 3, en=0 hold 2, wait 5.
//     ack_o rises and busy_o falls exactly 12 cycles after accept.
//  3. Write 32'h0000_0001 with ack_o=1 (REQ=0, clear) -> en high for 3 cycles; ack_o returns to 0 after 27 cycles.
//     Repeat with data 8'h38 -> ack_o after 12 cycles.
//  4. Toggle REQ during INIT (cycle 5) -> command is accepted on the first IDLE cycle (cycle 10) and executes normally.
//  5. Assert rst_ni low while en=1 -> en, rs, data and ack_o go to 0 in the same cycle without a clock edge.
//     After release, busy_o=1 for 10 cycles.
//  6. Toggle bit31 alone while busy -> lcd_on_o follows after 1 cycle; the command timing is unaffected.

Source files
------------

// File: rtl/lcd_port_driver.sv
// HD44780 write-cycle generator fed by the core's LCD output register.
// Each REQ toggle becomes setup / EN pulse / hold / settle, acknowledged by echoing REQ on ack_o.
module lcd_port_driver #(
    parameter int T_POWERUP    = 1000000,
    parameter int T_SETUP      = 4,
    parameter int T_PULSE      = 25,
    parameter int T_HOLD       = 4,
    parameter int T_WAIT_SHORT = 2000,
    parameter int T_WAIT_LONG  = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lcd_word_i,
    output logic        lcd_on_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic [7:0]  lcd_data_o,
    output logic        busy_o,
    output logic        ack_o
);

    localparam int M_A   = (T_POWERUP > T_SETUP) ? T_POWERUP : T_SETUP;
    localparam int M_B   = (T_PULSE > T_HOLD) ? T_PULSE : T_HOLD;
    localparam int M_C   = (T_WAIT_SHORT > T_WAIT_LONG) ? T_WAIT_SHORT : T_WAIT_LONG;
    localparam int M_AB  = (M_A > M_B) ? M_A : M_B;
    localparam int T_MAX = (M_AB > M_C) ? M_AB : M_C;
    localparam int CNT_W = $clog2(T_MAX) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_ONE    = cnt_t'(1);
    localparam cnt_t LD_INIT    = cnt_t'(T_POWERUP - 1);
    localparam cnt_t LD_SETUP   = cnt_t'(T_SETUP);
    localparam cnt_t LD_PULSE   = cnt_t'(T_PULSE);
    localparam cnt_t LD_HOLD    = cnt_t'(T_HOLD);
    localparam cnt_t LD_W_SHORT = cnt_t'(T_WAIT_SHORT);
    localparam cnt_t LD_W_LONG  = cnt_t'(T_WAIT_LONG);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic        on_q, on_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        req_q, req_d;
    logic        cnt_last;
    logic        unused_word_bits;

    // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
    function automatic logic is_long_wait(input logic rs, input logic [7:0] d);
        return (rs == 1'b0) && (d[7:2] == 6'd0) && (d[1:0] != 2'd0);
    endfunction

    assign unused_word_bits = ^lcd_word_i[29:9];
    assign cnt_last         = (cnt_q <= CNT_ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        on_d    = lcd_word_i[31];
        rs_d    = rs_q;
        data_d  = data_q;
        req_d   = req_q;
        ack_d   = ack_q;

        case (state_q)
            S_INIT: begin
                // A zero count only exists straight out of reset; it arms the power-up delay.
                if (cnt_q == '0 && T_POWERUP > 1) begin
                    cnt_d = LD_INIT;
                end else if (cnt_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_IDLE: begin
                if (lcd_word_i[30] != ack_q) begin
                    rs_d    = lcd_word_i[8];
                    data_d  = lcd_word_i[7:0];
                    req_d   = lcd_word_i[30];
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_last) begin
                    state_d = S_PULSE;
                    cnt_d   = LD_PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_PULSE: begin
                if (cnt_last) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_last) begin
                    state_d = S_WAIT;
                    cnt_d   = is_long_wait(rs_q, data_q) ? LD_W_LONG : LD_W_SHORT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WAIT: begin
                if (cnt_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ack_d   = req_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase

        en_d   = (state_d == S_PULSE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            on_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            on_q    <= on_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            req_q   <= req_d;
        end
    end

    assign lcd_on_o   = on_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_en_o   = en_q;
    assign lcd_data_o = data_q;
    assign busy_o     = busy_q;
    assign ack_o      = ack_q;

endmodule

// File: tb/tb_lcd_port_driver.sv
// Bench for lcd_port_driver: command table, multi-cycle corner cases and random traffic
// checked every cycle against a schedule-based reference model.
module tb_lcd_port_driver;

    localparam int T_POWERUP    = 10;
    localparam int T_SETUP      = 2;
    localparam int T_PULSE      = 3;
    localparam int T_HOLD       = 2;
    localparam int T_WAIT_SHORT = 5;
    localparam int T_WAIT_LONG  = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] word = 32'h0;
    logic        lcd_on, lcd_rs, lcd_rw, lcd_en, busy, ack;
    logic [7:0]  lcd_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lcd_port_driver #(
        .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE),
        .T_HOLD(T_HOLD), .T_WAIT_SHORT(T_WAIT_SHORT), .T_WAIT_LONG(T_WAIT_LONG)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .lcd_word_i(word),
        .lcd_on_o(lcd_on), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw), .lcd_en_o(lcd_en),
        .lcd_data_o(lcd_data), .busy_o(busy), .ack_o(ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a command is a schedule of edges counted from its accept edge.
    int         m_t = 0;
    int         m_pos = 0;
    int         m_total = 0;
    bit         m_initd = 1'b0;
    bit         m_active = 1'b0;
    bit         m_req = 1'b0;
    bit         m_rs = 1'b0;
    bit         m_on = 1'b0;
    bit         m_ack = 1'b0;
    logic [7:0] m_data = 8'h00;

    function automatic int settle(input logic rs, input logic [7:0] d);
        if (!rs && d <= 8'd3 && d != 8'd0) return T_WAIT_LONG;
        return T_WAIT_SHORT;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0; m_pos <= 0; m_total <= 0; m_initd <= 1'b0; m_active <= 1'b0;
            m_req <= 1'b0; m_rs <= 1'b0; m_on <= 1'b0; m_ack <= 1'b0; m_data <= 8'h00;
        end else begin
            m_on <= word[31];
            if (!m_initd) begin
                m_t <= m_t + 1;
                if (m_t + 1 == T_POWERUP) m_initd <= 1'b1;
            end else if (!m_active) begin
                if (word[30] != m_ack) begin
                    m_active <= 1'b1;
                    m_pos    <= 0;
                    m_req    <= word[30];
                    m_rs     <= word[8];
                    m_data   <= word[7:0];
                    m_total  <= T_SETUP + T_PULSE + T_HOLD + settle(word[8], word[7:0]);
                end
            end else begin
                m_pos <= m_pos + 1;
                if (m_pos + 1 == m_total) begin
                    m_active <= 1'b0;
                    m_ack    <= m_req;
                end
            end
        end
    end

    function automatic logic [13:0] expected_vec();
        logic en_e;
        en_e = m_active && (m_pos >= T_SETUP) && (m_pos < T_SETUP + T_PULSE);
        return {m_on, m_rs, 1'b0, en_e, m_data, (!m_initd) || m_active, m_ack};
    endfunction

    always @(negedge clk) begin
        check("outputs{on,rs,rw,en,data,busy,ack}",
              32'({lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_data, busy, ack}), 32'(expected_vec()));
    end

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         lat;
    } vec_t;

    vec_t tbl[9];

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_cmd(input logic rs, input logic [7:0] d, input int flip_at,
                           output int lat, output int en_cnt);
        logic r;
        int   n;
        wait_idle();
        r = ~ack;
        word = {word[31], r, 21'd0, rs, d};
        n = 0;
        en_cnt = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (lcd_en) en_cnt++;
            if (n == 1) begin
                check("accept_rs", 32'(lcd_rs), 32'(rs));
                check("accept_data", 32'(lcd_data), 32'(d));
                check("accept_busy", 32'(busy), 32'd1);
            end
            if (flip_at > 0 && n == flip_at) word[31] = ~word[31];
            if (flip_at > 0 && n == flip_at + 1) check("on_follow", 32'(lcd_on), 32'(word[31]));
        end while (ack != r && n < 200);
        lat = n - 1;
    endtask

    task automatic count_init_edges(output int n);
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            check("init_en_low", 32'(lcd_en), 32'd0);
            check("init_ack_low", 32'(ack), 32'd0);
        end
    endtask

    initial begin
        int          lat, ec, n;
        logic [31:0] tmp;
        logic [7:0]  d;
        int          sel;

        tbl[0] = '{1'b1, 8'h41, 12};
        tbl[1] = '{1'b0, 8'h01, 27};
        tbl[2] = '{1'b0, 8'h38, 12};
        tbl[3] = '{1'b0, 8'h02, 27};
        tbl[4] = '{1'b0, 8'h03, 27};
        tbl[5] = '{1'b0, 8'h04, 12};
        tbl[6] = '{1'b0, 8'h00, 12};
        tbl[7] = '{1'b1, 8'h01, 12};
        tbl[8] = '{1'b0, 8'h81, 12};

        // Power-up: busy for exactly T_POWERUP edges
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_en", 32'(lcd_en), 32'd0);
        check("reset_data", 32'(lcd_data), 32'd0);
        rst_n = 1'b1;
        count_init_edges(n);
        check("powerup_edges", 32'(n), 32'd10);

        // Command table, issued back to back
        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].rs, tbl[i].data, 0, lat, ec);
            check("cmd_latency", 32'(lat), 32'(tbl[i].lat));
            check("cmd_en_cycles", 32'(ec), 32'd3);
            check("cmd_busy_done", 32'(busy), 32'd0);
            check("retain_data", 32'(lcd_data), 32'(tbl[i].data));
        end

        // ON bit toggled mid-command does not disturb timing
        run_cmd(1'b1, 8'h55, 4, lat, ec);
        check("on_toggle_latency", 32'(lat), 32'd12);
        check("on_toggle_en", 32'(ec), 32'd3);

        // Reset asserted while EN is high
        if (ack == 1'b0) run_cmd(1'b0, 8'h38, 0, lat, ec);
        wait_idle();
        word = {1'b1, ~ack, 21'd0, 1'b1, 8'h5A};
        n = 0;
        while (!lcd_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_pulse", 32'(lcd_en), 32'd1);
        check("pre_reset_ack", 32'(ack), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_en", 32'(lcd_en), 32'd0);
        check("async_rs", 32'(lcd_rs), 32'd0);
        check("async_data", 32'(lcd_data), 32'd0);
        check("async_ack", 32'(ack), 32'd0);
        check("async_on", 32'(lcd_on), 32'd0);
        check("async_busy", 32'(busy), 32'd1);
        word = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_init_edges(n);
        check("reinit_edges", 32'(n), 32'd10);

        // REQ toggled during INIT is served on the first IDLE cycle
        @(negedge clk);
        rst_n = 1'b0;
        word = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (5) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        word = 32'h4000_0041;
        while (ack != 1'b1 && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("init_req_ack_edge", 32'(n), 32'd23);

        // Random traffic against the model
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(1, 6)) @(negedge clk);
            sel = $urandom_range(0, 9);
            if (sel < 5 && !busy) begin
                tmp = $urandom;
                d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : tmp[7:0];
                word[29:9] = tmp[31:11];
                word[8]    = tmp[8];
                word[7:0]  = d;
                word[30]   = ~ack;
            end else if (sel < 7) begin
                word[31] = ~word[31];
            end else if (sel < 8 && busy) begin
                word[30] = ~word[30];
                @(negedge clk);
                word[30] = ~word[30];
            end else if (busy) begin
                tmp = $urandom;
                word[29:0] = tmp[29:0];
            end
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
